// File: rtl/echo_indication_input_pkg.sv
// Shared definitions for the 96-bit echo indication pipe (serializer and deserializer).
package echo_indication_input_pkg;

  localparam int unsigned MSG_W     = 96;
  localparam int unsigned FIELD_W   = 32;
  localparam int unsigned PAYLOAD_W = 2 * FIELD_W;

  localparam int unsigned TAG_LSB  = 0;
  localparam int unsigned METH_LSB = 32;
  localparam int unsigned V_LSB    = 64;

  localparam logic [FIELD_W-1:0] TAG_HEARD_DEFAULT = 32'd1;

  // Wire format of one pipe message
  typedef struct packed {
    logic [FIELD_W-1:0] v;
    logic [FIELD_W-1:0] meth;
    logic [FIELD_W-1:0] tag;
  } echo_msg_t;

  // Buffered payload of a heard call
  typedef struct packed {
    logic [FIELD_W-1:0] meth;
    logic [FIELD_W-1:0] v;
  } echo_payload_t;

endpackage

// File: rtl/echo_pingpong_buf.sv
// Two-entry ping-pong buffer; output reads zero whenever the head slot is empty.
module echo_pingpong_buf #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              enq__ENA,
  input  logic [DATA_W-1:0] enq_v,
  output logic              enq__RDY,
  output logic              deq__ENA,
  output logic [DATA_W-1:0] deq_v,
  input  logic              deq__RDY
);

  logic [DATA_W-1:0] slot [2];
  logic [1:0]        valid;
  logic [1:0]        valid_nxt;
  logic              wr_sel;
  logic              rd_sel;
  logic              enq_fire;
  logic              deq_fire;

  assign enq__RDY = !valid[wr_sel];
  assign deq__ENA = valid[rd_sel];
  assign deq_v    = valid[rd_sel] ? slot[rd_sel] : '0;

  assign enq_fire = enq__ENA & enq__RDY;
  assign deq_fire = deq__ENA & deq__RDY;

  // Next occupancy: enqueue and dequeue always hit different slots when both fire
  always_comb begin
    valid_nxt = valid;
    if (deq_fire) valid_nxt[rd_sel] = 1'b0;
    if (enq_fire) valid_nxt[wr_sel] = 1'b1;
  end

  // Slot storage, occupancy and the two free-running 1-bit pointers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 2; i++) slot[i] <= '0;
      valid  <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
    end else begin
      valid <= valid_nxt;
      if (enq_fire) begin
        slot[wr_sel] <= enq_v;
        wr_sel       <= ~wr_sel;
      end
      if (deq_fire) rd_sel <= ~rd_sel;
    end
  end

endmodule

// File: rtl/echo_indication_input.sv
// Receive side of the echo indication pipe: tag decode, buffering and replay as heard calls.
module echo_indication_input
  import echo_indication_input_pkg::*;
#(
  parameter logic [31:0] TAG_HEARD = TAG_HEARD_DEFAULT,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pipe_enq__ENA,
  input  logic [MSG_W-1:0] pipe_enq_v,
  output logic             pipe_enq__RDY,
  output logic             indication_heard__ENA,
  output logic [31:0]      indication_heard_meth,
  output logic [31:0]      indication_heard_v,
  input  logic             indication_heard__RDY,
  output logic [ERR_W-1:0] bad_tag_count
);

  logic [FIELD_W-1:0] msg_tag;
  logic               tag_good;
  logic               buf_enq_ena;
  logic               bad_fire;
  echo_payload_t      enq_payload;
  echo_payload_t      deq_payload;

  assign msg_tag          = pipe_enq_v[TAG_LSB +: FIELD_W];
  assign enq_payload.meth = pipe_enq_v[METH_LSB +: FIELD_W];
  assign enq_payload.v    = pipe_enq_v[V_LSB +: FIELD_W];

  assign tag_good    = (msg_tag == TAG_HEARD);
  assign buf_enq_ena = pipe_enq__ENA & tag_good;
  // A bad message is consumed only when the block could have accepted it
  assign bad_fire    = pipe_enq__ENA & pipe_enq__RDY & !tag_good;

  echo_pingpong_buf #(
    .DATA_W (PAYLOAD_W)
  ) u_buf (
    .CLK      (CLK),
    .nRST     (nRST),
    .enq__ENA (buf_enq_ena),
    .enq_v    (enq_payload),
    .enq__RDY (pipe_enq__RDY),
    .deq__ENA (indication_heard__ENA),
    .deq_v    (deq_payload),
    .deq__RDY (indication_heard__RDY)
  );

  assign indication_heard_meth = deq_payload.meth;
  assign indication_heard_v    = deq_payload.v;

  // Saturating count of messages dropped for an unknown tag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bad_tag_count <= '0;
    end else if (bad_fire && (bad_tag_count != '1)) begin
      bad_tag_count <= bad_tag_count + ERR_W'(1);
    end
  end

endmodule

// File: doc/echo_indication_input.md
# echo_indication_input

Receive side of the echo indication pipe. Accepts 96-bit serialized indication messages from the pipe and decodes the tag. Buffers valid messages in a two-entry ping-pong store and replays each one as an `indication$heard` method call toward the software-facing consumer. It is the inverse of the indication output serializer and sits at the far end of the same 96-bit pipe.

## Interface
Parameters:
- TAG_HEARD, 32'd1, tag value identifying a `heard` message.
- ERR_W, 16, width of the dropped-message counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; asynchronous assert, active-low.
- pipe$enq__ENA  in  1  message offered this cycle.
- pipe$enq$v  in  96  message: [95:64] v, [63:32] meth, [31:0] tag.
- pipe$enq__RDY  out  1  block can accept a message.
- indication$heard__ENA  out  1  decoded method call valid.
- indication$heard$meth  out  32  decoded meth field.
- indication$heard$v  out  32  decoded v field.
- indication$heard__RDY  in  1  consumer accepts the call.
- bad_tag_count  out  ERR_W  saturating count of messages dropped for an unknown tag.

## Operation
- State:
  - slot0/slot1, each holding {meth, v};
  - valid[1:0];
  - wr_sel (write pointer, 1 bit);
  - rd_sel (read pointer, 1 bit);
  - bad_tag_count.
- pipe$enq__RDY = !valid[wr_sel]. It is 0 only when both slots are valid.
- Enqueue fires when pipe$enq__ENA & pipe$enq__RDY:
  - If tag == TAG_HEARD: write meth/v into slot[wr_sel], set valid[wr_sel], toggle wr_sel.
  - Otherwise: the message is consumed and discarded. No slot is written, wr_sel is unchanged, and bad_tag_count increments, saturating at all-ones.
- pipe$enq__ENA while RDY = 0 is ignored. The sender must hold the message.
- indication$heard__ENA = valid[rd_sel].
- meth/v are driven from slot[rd_sel] when valid. Otherwise they are driven to 0, never stale data.
- Dequeue fires when indication$heard__ENA & indication$heard__RDY: clear valid[rd_sel], toggle rd_sel.
- Simultaneous enqueue and dequeue in one cycle are both performed. They touch different slots whenever enqueue is allowed, and then valid is unchanged in count.
- Wrap-around: pointers are 1 bit and toggle freely, so no extra handling is needed.
- Message order on the output equals acceptance order of good-tag messages.

## Timing
- Reset, asynchronous on nRST low. Takes effect immediately, mid-transfer included. In-flight buffered messages are lost.
  - valid = 0, wr_sel = rd_sel = 0, slots = 0, bad_tag_count = 0.
  - Outputs: pipe$enq__RDY = 1 (registered state only), indication$heard__ENA = 0, meth = v = 0, bad_tag_count = 0.
- Latency: a good message accepted at edge N makes indication$heard__ENA 1 in the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 message/cycle sustained when the consumer holds RDY = 1.
- Both __RDY outputs and __ENA outputs are functions of registered state only. There is no combinational input-to-output path.
- bad_tag_count updates at the edge of the offending enqueue.

## Structure
- Shared package (with the output serializer) holds:
  - MSG_W = 96;
  - field offsets TAG_LSB = 0, METH_LSB = 32, V_LSB = 64;
  - tag constant TAG_HEARD_DEFAULT = 1;
  - the packed message typedef {v, meth, tag}.
- One sub-module, echo_pingpong_buf: generic two-entry 64-bit buffer with enq/deq ENA/RDY and zero-when-empty output.
- The top level adds tag decode and the error counter.

## Test plan
- Reset release, then send {v=0x0000002A, meth=0x5, tag=1}. Required: heard__ENA = 1 one cycle later with meth = 5, v = 0x2A. Hold RDY = 0 for 3 cycles and the data must be stable; RDY = 1 then dequeues and ENA drops.
- Hold heard__RDY = 0 and send 3 good messages. Required: first two accepted, pipe$enq__RDY = 0 after the second, third held. Release RDY: outputs appear in order 1, 2, 3.
- Send tag = 7 twice, then tag = 1. Required: bad_tag_count = 2, no heard__ENA for the bad messages, and the good message is delivered normally.
- Streaming: 100 back-to-back good messages with RDY = 1. Required: 100 in-order outputs, pipe$enq__RDY never 0.
- Force bad_tag_count to all-ones and send a bad tag. Required: the count stays at 0xFFFF.
- With 2 messages buffered, pulse nRST low mid-cycle. Required: ENA = 0 and RDY = 1 immediately, and no stale output after release.
